// File: rtl/slc3_pkg.sv
// Shared types and constants for the memory access unit.
package slc3_pkg;

    localparam int DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/load_reg.sv
// Plain load-enable register with asynchronous active-low clear.
module load_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d on a load, clear to zero while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MAR/MDR pair plus a small sequencer that holds the memory enables for
// LATENCY cycles and strobes ready in the final cycle of each access.
//
//   state | meaning
//   IDLE  | no access; MAR/MDR loads and starts accepted
//   READ  | read of MAR in progress; MDR captures mem_rdata in last cycle
//   WRITE | write of MDR to MAR in progress
module mem_access_unit
    import slc3_pkg::mem_state_t;
    import slc3_pkg::IDLE;
    import slc3_pkg::READ;
    import slc3_pkg::WRITE;
#(
    parameter int DATA_WIDTH = slc3_pkg::DATA_WIDTH,
    parameter int LATENCY    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] bus_data,
    input  logic                  ld_mar,
    input  logic                  ld_mdr,
    input  logic                  start_read,
    input  logic                  start_write,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] mar_out,
    output logic [DATA_WIDTH-1:0] mdr_out,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_ce,
    output logic                  mem_we,
    output logic                  busy,
    output logic                  ready
);

    mem_state_t state, state_nxt;
    logic [3:0] count;
    logic       in_idle;
    logic       last_cycle;
    logic       start_any;
    logic       capture;
    logic       mdr_load;
    logic [DATA_WIDTH-1:0] mdr_d;

    assign in_idle    = (state == IDLE);
    assign last_cycle = !in_idle && (count == 4'd0);
    assign start_any  = in_idle && (start_read || start_write);
    assign capture    = (state == READ) && last_cycle;

    // MDR is fed from memory only on the read-capture edge; otherwise from the bus.
    assign mdr_d    = capture ? mem_rdata : bus_data;
    assign mdr_load = (in_idle && ld_mdr) || capture;

    load_reg #(.WIDTH(DATA_WIDTH)) u_mar (
        .clk   (clk),
        .reset (reset),
        .load  (in_idle && ld_mar),
        .d     (bus_data),
        .q     (mar_out)
    );

    load_reg #(.WIDTH(DATA_WIDTH)) u_mdr (
        .clk   (clk),
        .reset (reset),
        .load  (mdr_load),
        .d     (mdr_d),
        .q     (mdr_out)
    );

    assign mem_addr  = mar_out;
    assign mem_wdata = mdr_out;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Access down-counter: loads on entry, terminal count marks the last cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 4'd0;
        end else if (start_any) begin
            count <= 4'(LATENCY - 1);
        end else if (!in_idle && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    // Next-state and per-state memory strobes; read wins over a coincident write.
    always_comb begin
        state_nxt = state;
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b0;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                if (start_read) begin
                    state_nxt = READ;
                end else if (start_write) begin
                    state_nxt = WRITE;
                end
            end
            READ: begin
                mem_ce = 1'b1;
                busy   = 1'b1;
                ready  = last_cycle;
                if (last_cycle) state_nxt = IDLE;
            end
            WRITE: begin
                mem_ce = 1'b1;
                mem_we = 1'b1;
                busy   = 1'b1;
                ready  = last_cycle;
                if (last_cycle) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the bus, MAR, MDR and memory data/address width.
REQ-002 Parameter LATENCY, default 3, SHALL set the number of memory cycles per access; legal range is 1..15.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 bus_data  input  16  SHALL be the processor bus value, the source for MAR and MDR loads.
REQ-006 ld_mar  input  1  SHALL load MAR from bus_data.
REQ-007 ld_mdr  input  1  SHALL load MDR from bus_data.
REQ-008 start_read  input  1  SHALL request a memory read at address MAR.
REQ-009 start_write  input  1  SHALL request a memory write of MDR to address MAR.
REQ-010 mem_rdata  input  16  SHALL be the memory read data, valid during the last access cycle.
REQ-011 mar_out  output  16  SHALL be the current MAR contents.
REQ-012 mdr_out  output  16  SHALL be the current MDR contents, the source the bus gate and the register file consume.
REQ-013 mem_addr  output  16  SHALL equal MAR.
REQ-014 mem_wdata  output  16  SHALL equal MDR.
REQ-015 mem_ce  output  1  SHALL be the memory chip enable.
REQ-016 mem_we  output  1  SHALL be the memory write enable.
REQ-017 busy  output  1  SHALL be high while an access is in progress.
REQ-018 ready  output  1  SHALL be a single-cycle access-complete strobe (the LC-3 "R" signal).

Function
REQ-019 The FSM SHALL have three states.
- IDLE: exit to READ on start_read, else to WRITE on start_write.
- READ and WRITE: return to IDLE after LATENCY cycles.
REQ-020 On entering READ or WRITE, a down-counter SHALL load LATENCY-1 and decrement once per cycle; the last cycle is count==0.
REQ-021 Outputs per state SHALL be:
- READ: mem_ce=1, mem_we=0, busy=1.
- WRITE: mem_ce=1, mem_we=1, busy=1.
- IDLE: mem_ce=0, mem_we=0, busy=0.
REQ-022 ready SHALL be combinational high only in the last READ or WRITE cycle, and low otherwise.
REQ-023 On the clock edge ending the last READ cycle, MDR SHALL capture mem_rdata.
REQ-024 Access latency SHALL be LATENCY cycles from the first cycle after the start is sampled to the ready cycle; the next start is accepted in the following IDLE cycle.
REQ-025 If start_read and start_write are both high in IDLE, the read SHALL proceed and the write SHALL be dropped.
REQ-026 start_read and start_write SHALL be ignored outside IDLE; no queuing.
REQ-027 ld_mar and ld_mdr SHALL take effect only in IDLE and are ignored while busy, so address and data stay stable during an access.
REQ-028 In IDLE, ld_mar and ld_mdr together SHALL load both registers from bus_data.
REQ-029 If ld_mar or ld_mdr coincides with a start in IDLE, the load SHALL occur first and the access SHALL use the newly loaded value from its first cycle.

Reset
REQ-030 While reset is low, the block SHALL immediately force:
- state to IDLE;
- MAR, MDR and counter to 0;
- mem_ce, mem_we, busy and ready to 0.
REQ-031 Reset asserted mid-access SHALL abort the access with no MDR capture and no ready pulse.
REQ-032 After reset deasserts, the block SHALL accept a start on the first subsequent edge.

Structure
REQ-033 The package slc3_pkg SHALL hold the mem_state_t enum (IDLE, READ, WRITE) and the DATA_WIDTH constant.
REQ-034 MAR and MDR SHALL be built from the existing load_reg sub-module (DATA_WIDTH 16). MDR load data SHALL be muxed between bus_data and mem_rdata, with a load enable from ld_mdr&IDLE or the read-capture condition.
REQ-035 The FSM and counter SHALL be local to mem_access_unit; no other sub-modules.

Verification
REQ-036 Read, LATENCY=3:
- Stimulus: bus_data=x3000 with ld_mar, then start_read; mem_rdata=x1234 in the last cycle.
- Response: mem_ce high for exactly 3 cycles, ready on the 3rd, mdr_out=x1234 on the next cycle, busy low.
REQ-037 Write:
- Stimulus: ld_mar with x0042, ld_mdr with xBEEF, then start_write.
- Response: mem_addr=x0042, mem_wdata=xBEEF and mem_we=1 for 3 cycles, one ready pulse, MDR unchanged.
REQ-038 Simultaneous start_read and start_write in IDLE -> read only; mem_we stays 0 throughout.
REQ-039 During a read:
- Stimulus: ld_mar with x5555, ld_mdr with xAAAA and start_write asserted.
- Response: all ignored; mar_out unchanged; exactly one ready pulse.
REQ-040 Reset pulsed low in the 2nd READ cycle -> all outputs 0 immediately, no ready, mdr_out=0; a fresh read afterwards completes normally.
REQ-041 LATENCY=1 -> ready is asserted in the first access cycle, and back-to-back reads complete every 2 cycles.
